// File: rtl/pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_pkg : shared types and per-boundary NOP encodings for elastic stages
// Revision : 1.0
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } pipe_state_e;

  // ID/EX bubble must not start a multiply/divide (mul_div_op = 4'b1111 is idle)
  localparam logic [15:0] C_NOP_IF_ID  = 16'h0000;
  localparam logic [15:0] C_NOP_ID_EX  = 16'h000F;
  localparam logic [15:0] C_NOP_EX_MEM = 16'h0000;
  localparam logic [15:0] C_NOP_MEM_WB = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_entry.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_skid_entry : valid flag plus control/data payload register
// Revision : 1.0
// ---------------------------------------------------------------------------
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int                CTRL_W   = 16,
  parameter int                DATA_W   = 128,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_clr_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Control is forced to NOP whenever the entry goes invalid, so it can be
  // presented downstream without an output mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_ctrl  <= NOP_CTRL;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= NOP_CTRL;
      if (i_clr_data) r_data <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_elastic : valid/ready pipeline register with 2-entry skid buffer
// Revision : 1.0
// ---------------------------------------------------------------------------
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                CTRL_W   = 16,
  parameter int                DATA_W   = 128,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter bit                CLR_DATA = 1'b1,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e       r_state;
  pipe_state_e       w_state_nxt;
  logic              r_in_ready;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_acc, w_drn, w_clr_data;
  logic              w_main_load, w_main_clear, w_main_sel_skid;
  logic              w_skid_load, w_skid_clear;
  logic              w_main_valid, w_skid_valid;
  logic [CTRL_W-1:0] w_skid_ctrl, w_main_ctrl_in;
  logic [DATA_W-1:0] w_skid_data, w_main_data_in;

  assign w_acc      = in_valid && r_in_ready;
  assign w_drn      = w_main_valid && out_ready;
  assign w_clr_data = flush && CLR_DATA;

  always_comb begin
    w_state_nxt     = r_state;
    w_main_load     = 1'b0;
    w_main_clear    = 1'b0;
    w_main_sel_skid = 1'b0;
    w_skid_load     = 1'b0;
    w_skid_clear    = 1'b0;
    if (flush) begin
      w_state_nxt  = PS_EMPTY;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        PS_EMPTY: if (w_acc) begin
          w_main_load = 1'b1;
          w_state_nxt = PS_FULL;
        end
        PS_FULL: begin
          if (w_acc && w_drn) begin
            w_main_load = 1'b1;
          end else if (w_acc) begin
            w_skid_load = 1'b1;
            w_state_nxt = PS_SKID;
          end else if (w_drn) begin
            w_main_clear = 1'b1;
            w_state_nxt  = PS_EMPTY;
          end
        end
        PS_SKID: if (w_drn) begin
          w_main_load     = 1'b1;
          w_main_sel_skid = 1'b1;
          w_skid_clear    = 1'b1;
          w_state_nxt     = PS_FULL;
        end
        default: w_state_nxt = PS_EMPTY;
      endcase
    end
  end

  assign w_main_ctrl_in = w_main_sel_skid ? w_skid_ctrl : in_ctrl;
  assign w_main_data_in = w_main_sel_skid ? w_skid_data : in_data;

  // in_ready is a pure flop: low exactly while the skid entry is occupied
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= PS_EMPTY;
      r_in_ready  <= 1'b1;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != PS_SKID);
      if (w_main_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  pipe_skid_entry #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .NOP_CTRL (NOP_CTRL)
  ) u_main (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_main_load),
    .i_clear    (w_main_clear),
    .i_clr_data (w_clr_data),
    .i_ctrl     (w_main_ctrl_in),
    .i_data     (w_main_data_in),
    .o_valid    (w_main_valid),
    .o_ctrl     (out_ctrl),
    .o_data     (out_data)
  );

  pipe_skid_entry #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .NOP_CTRL (NOP_CTRL)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_skid_load),
    .i_clear    (w_skid_clear),
    .i_clr_data (w_clr_data),
    .i_ctrl     (in_ctrl),
    .i_data     (in_data),
    .o_valid    (w_skid_valid),
    .o_ctrl     (w_skid_ctrl),
    .o_data     (w_skid_data)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = w_main_valid;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_stage_elastic : directed + random scoreboard bench for the stage
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_pipe_stage_elastic;

  localparam int          CW  = 8;
  localparam int          DW  = 16;
  localparam logic [7:0]  NOP = 8'hA5;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt;
  logic          in_ready2, out_valid2;
  logic [CW-1:0] out_ctrl2;
  logic [DW-1:0] out_data2;
  logic [1:0]    stall_cnt2;

  int n_assert = 0;
  int n_fail   = 0;
  int n_drn    = 0;
  logic [CW+DW-1:0] q[$];
  logic [CW+DW-1:0] exp_beat;
  logic             prev_stall = 1'b0;
  logic [CW-1:0]    hold_c;
  logic [DW-1:0]    hold_d;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .NOP_CTRL(NOP), .CLR_DATA(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt)
  );

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .NOP_CTRL(NOP), .CLR_DATA(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
    .out_ctrl(out_ctrl2), .out_data(out_data2), .stall_cnt(stall_cnt2)
  );

  assert property (@(posedge clk) disable iff (reset) in_ready == !dut.u_skid.o_valid)
    else $error("FAIL sva_in_ready observed=%0b skid_valid=%0b", in_ready, dut.u_skid.o_valid);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  // One clock: scoreboard work at the negedge, then return 1 time unit after posedge.
  task automatic tick();
    @(negedge clk);
    if (prev_stall) begin
      chk("hold_ctrl", 64'(out_ctrl), 64'(hold_c));
      chk("hold_data", 64'(out_data), 64'(hold_d));
    end
    prev_stall = !reset && !flush && out_valid && !out_ready;
    hold_c = out_ctrl;
    hold_d = out_data;
    if (reset) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_drn++;
        if (q.size() == 0) begin
          chk("unexpected_beat", 64'(out_ctrl), 64'(NOP));
        end else begin
          exp_beat = q.pop_front();
          chk("sb_ctrl", 64'(out_ctrl), 64'(exp_beat[CW+DW-1:DW]));
          chk("sb_data", 64'(out_data), 64'(exp_beat[DW-1:0]));
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back({in_ctrl, in_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    tick();
    tick();
  endtask

  initial begin
    int d0;
    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_ctrl",  64'(out_ctrl),  64'(NOP));
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    reset = 1'b0;

    // 1: streaming at full rate
    out_ready = 1'b1;
    d0 = n_drn;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CW'(i), DW'(i * 16'h0111));
      tick();
      chk("stream_latency_valid", 64'(out_valid), 64'd1);
      chk("stream_latency_ctrl",  64'(out_ctrl),  64'(i));
    end
    drive(1'b0, '0, '0);
    tick();
    chk("stream_drains", 64'(n_drn - d0), 64'd8);
    chk("stream_stall_cnt", 64'(stall_cnt), 64'd0);
    tick();
    chk("stream_empty_ctrl", 64'(out_ctrl), 64'(NOP));

    // 2: back-pressure with A, B, C
    do_reset(); reset = 1'b0;
    drive(1'b1, 8'h0A, 16'hAAAA); tick();
    drive(1'b1, 8'h0B, 16'hBBBB); tick();
    drive(1'b1, 8'h0C, 16'hCCCC); tick();
    tick();
    chk("bp_out_ctrl_A", 64'(out_ctrl), 64'h0A);
    chk("bp_out_data_A", 64'(out_data), 64'hAAAA);
    chk("bp_in_ready",   64'(in_ready), 64'd0);
    chk("bp_stall_cnt",  64'(stall_cnt), 64'd3);
    chk("bp_skid_B",     64'(q.size()), 64'd2);
    out_ready = 1'b1;
    tick();
    tick();
    drive(1'b0, '0, '0);
    tick();
    tick();
    chk("bp_all_drained", 64'(q.size()), 64'd0);
    chk("bp_stall_hold",  64'(stall_cnt), 64'd3);

    // 3: flush while SKID
    do_reset(); reset = 1'b0;
    drive(1'b1, 8'h11, 16'h1111); tick();
    drive(1'b1, 8'h22, 16'h2222); tick();
    chk("fl_pre_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 8'h33, 16'h3333); tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_out_ctrl",  64'(out_ctrl),  64'(NOP));
    chk("fl_out_data",  64'(out_data),  64'd0);
    chk("fl_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("fl_no_beat", 64'(out_valid), 64'd0);

    // 5: counter saturation on the CNT_W=2 instance
    do_reset(); reset = 1'b0;
    drive(1'b1, 8'h44, 16'h4444); tick();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 3; i++) tick();
    chk("sat_reach3", 64'(stall_cnt2), 64'd3);
    for (int i = 0; i < 3; i++) tick();
    chk("sat_hold3",  64'(stall_cnt2), 64'd3);
    chk("sat_wide6",  64'(stall_cnt),  64'd6);

    // 4: reset while FULL under back-pressure
    reset = 1'b1; tick();
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
    chk("mid_rst_out_ctrl",  64'(out_ctrl),  64'(NOP));
    chk("mid_rst_out_data",  64'(out_data),  64'd0);
    chk("mid_rst_stall_cnt", 64'(stall_cnt), 64'd0);
    reset = 1'b0;

    // 6: random valid/ready traffic
    for (int i = 0; i < 400; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), CW'($urandom), DW'($urandom));
      tick();
    end
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() != 0; k++) tick();
    chk("rand_sb_empty", 64'(q.size()), 64'd0);
    tick();
    chk("rand_out_idle", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
